// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands plus carry-in
// using a single 1-bit full adder, one bit per cycle, LSB first.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   start - begin an addition (accepted in IDLE or DONE)
//   a, b  - operands, captured on an accepted start
//   ci    - carry-in, captured on an accepted start
//   busy  - high while bits are being processed
//   done  - one-cycle pulse, sum/co valid
//   sum   - registered result, a+b+ci mod 2^WIDTH
//   co    - registered carry-out

// 1-bit full adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic fa_s;
  logic fa_co;

  // Shared datapath: always fed from the operand LSBs and the running carry.
  full_adder u_fa (
    .a  (opa_q[0]),
    .b  (opb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and output logic.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    co_d    = co_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts start exactly like IDLE for back-to-back operation.
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = b;
          carry_d = ci;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last bit: publish the shifted-in result and final carry directly.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          co_d    = fa_co;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign co   = co_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk edge.
REQ-005 a  input  WIDTH  operand A; captured only on an accepted start.
REQ-006 b  input  WIDTH  operand B; captured only on an accepted start.
REQ-007 ci  input  1  carry-in; captured only on an accepted start.
REQ-008 busy  output  1  high while bits are being processed (RUN state).
REQ-009 done  output  1  single-cycle pulse marking result valid.
REQ-010 sum  output  WIDTH  registered result, a+b+ci modulo 2^WIDTH.
REQ-011 co  output  1  registered carry-out of the WIDTH-bit addition.

Function
REQ-012 Datapath SHALL be exactly one instance of the team's 1-bit full_adder; controller time-multiplexes it LSB first, one bit per cycle.
REQ-013 Internal state: operand shift registers opa/opb (WIDTH each), carry flop, result shift register (WIDTH), bit counter (ceil(log2(WIDTH+1)) bits), FSM.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-015 IDLE: start=1 at edge T -> load opa=a, opb=b, carry=ci, count=0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN, each edge: full_adder inputs opa[0], opb[0], carry; result register shifts right with sum bit entering MSB; carry<=co bit; opa/opb shift right; count+=1.
REQ-017 RUN: on the edge where count reaches WIDTH -> go DONE, and copy the complete result to sum and final carry to co at the same edge.
REQ-018 Latency: start accepted at edge T -> busy high during cycles T..T+WIDTH-1 (WIDTH cycles), done high for exactly the cycle after edge T+WIDTH.
REQ-019 DONE lasts one cycle: start=1 -> accepted exactly as in IDLE (back-to-back, no bubble); start=0 -> IDLE.
REQ-020 start in RUN SHALL be ignored; a, b, ci changes in RUN SHALL not affect the result in progress.
REQ-021 sum/co SHALL change only at the RUN->DONE edge and hold their value through IDLE and subsequent RUN until the next completion.
REQ-022 busy and done SHALL be registered, mutually exclusive, never both high.
REQ-023 Overflow: carry out of bit WIDTH-1 appears only on co; sum wraps modulo 2^WIDTH.

Reset
REQ-024 rst_n low SHALL immediately (no clock) force FSM=IDLE, busy=0, done=0, sum=0, co=0, counter, carry and shift registers=0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation; no done pulse follows; sum/co read 0.
REQ-026 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x5A, b=0x3C, ci=0, start pulse -> busy 8 cycles, done 1 cycle, sum=0x96, co=0.
REQ-028 a=0xFF, b=0x01, ci=0 -> sum=0x00, co=1; a=0xFF, b=0xFF, ci=1 -> sum=0xFF, co=1.
REQ-029 a=0x10, b=0x20 started; start with a=0xFF, b=0xFF during cycle 3 of RUN -> ignored, result sum=0x30, co=0, single done pulse.
REQ-030 rst_n low for 1 cycle during RUN cycle 4 of a=0xAA, b=0x55 -> busy/done/sum/co=0 immediately, no done pulse, FSM IDLE.
REQ-031 start held high across DONE with a=0x01, b=0x01 then a=0x02, b=0x03 -> done pulses 9 cycles apart, results 0x02 then 0x05, busy low only during the DONE cycle.
REQ-032 Random self-check: >=1000 random a, b, ci with random start gaps -> every done matches {co,sum}=a+b+ci from the accepted start.
